// File: rtl/csma_backoff_ctl_pkg.sv
// Shared definitions for the xpu CSMA/CA channel-access sequencer.
// Holds the access FSM encoding, LFSR feedback mask and cw_exp width.
// No logic; imported by csma_backoff_ctl and lfsr16.
package csma_backoff_ctl_pkg;

  // Access FSM encoding (2-bit)
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IFS_WAIT = 2'd1,
    BACKOFF  = 2'd2,
    GRANT    = 2'd3
  } state_t;

  // Right-shifting Galois LFSR, taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Width of the contention-window exponent
  localparam int CW_EXP_W = 4;

endpackage

// File: rtl/csma_backoff_ctl_lfsr16.sv
// Purpose : free-running 16-bit Galois LFSR used as the backoff random source.
// Latency : state advances one step on every clock edge out of reset.
// Backpressure: none; never stalls.
// Ports   : clk, rstn (sync, active-low, loads SEED), state (current LFSR value).
module lfsr16
  import csma_backoff_ctl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/csma_backoff_ctl.sv
// Purpose : CSMA/CA access sequencer: IFS wait (SIFS + aifsn slots), then a
//           random backoff of 0..2^cw_exp-1 slots, then a one-cycle tx_grant.
// Latency : tx_req seen at edge k, idle channel, 0 slots -> tx_grant in cycle k+1+IFS.
// Backpressure: busy channel restarts IFS / freezes backoff; dropping tx_req
//           returns to IDLE and keeps the remaining slot count for the next request.
// Ports   : clk, rstn (sync active-low); tx_req, ch_idle (levels); cw_exp,
//           sifs_clks, slot_clks, aifsn (config, sampled at each IFS start);
//           tx_grant (pulse), bo_busy (IFS_WAIT|BACKOFF), bo_slots_left (status).
// Option  : define CSMA_FREEZE_CNT_EN to add freeze_cnt[15:0], a saturating count
//           of BACKOFF->IFS_WAIT freezes, cleared on GRANT.
module csma_backoff_ctl
  import csma_backoff_ctl_pkg::*;
#(
  parameter int          CNT_W     = 10,
  parameter int          BO_W      = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tx_req,
  input  logic                ch_idle,
  input  logic [CW_EXP_W-1:0] cw_exp,
  input  logic [CNT_W-1:0]    sifs_clks,
  input  logic [CNT_W-1:0]    slot_clks,
  input  logic [3:0]          aifsn,
  output logic                tx_grant,
  output logic                bo_busy,
  output logic [BO_W-1:0]     bo_slots_left
`ifdef CSMA_FREEZE_CNT_EN
  ,
  output logic [15:0]         freeze_cnt
`endif
);

  // Zero-length phases are stretched to one cycle
  function automatic logic [CNT_W-1:0] max1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Low min(e, BO_W) bits set; exponents above BO_W clamp naturally
  function automatic logic [BO_W-1:0] cw_mask(input logic [CW_EXP_W-1:0] e);
    logic [BO_W-1:0] m;
    m = '0;
    for (int i = 0; i < BO_W; i++) begin
      m[i] = (i < int'(e));
    end
    return m;
  endfunction

  state_t          state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic            in_slots, in_slots_nxt;   // IFS: 0 = SIFS part, 1 = AIFSN slots
  logic [3:0]      aifs_cnt, aifs_cnt_nxt;
  logic [CNT_W-1:0] sifs_len, sifs_len_nxt;
  logic [CNT_W-1:0] slot_len, slot_len_nxt;
  logic [3:0]      aifsn_r, aifsn_nxt;
  logic [BO_W-1:0] left_nxt;
  logic            frozen, frozen_nxt;       // remaining count owed to next request
  logic            restart_ifs;
  logic            ifs_done;
  logic [15:0]     lfsr_q;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .state (lfsr_q)
  );

  generate
    if (BO_W < 16) begin : g_lfsr_spare
      logic lfsr_unused;
      assign lfsr_unused = ^lfsr_q[15:BO_W];
    end
  endgenerate

  always_comb begin
    state_nxt    = state;
    clk_cnt_nxt  = clk_cnt;
    in_slots_nxt = in_slots;
    aifs_cnt_nxt = aifs_cnt;
    sifs_len_nxt = sifs_len;
    slot_len_nxt = slot_len;
    aifsn_nxt    = aifsn_r;
    left_nxt     = bo_slots_left;
    frozen_nxt   = frozen;
    restart_ifs  = 1'b0;
    ifs_done     = 1'b0;

    case (state)
      IDLE: begin
        if (tx_req) begin
          state_nxt   = IFS_WAIT;
          restart_ifs = 1'b1;
          if (!frozen) begin
            left_nxt = lfsr_q[BO_W-1:0] & cw_mask(cw_exp);
          end
        end
      end

      IFS_WAIT: begin
        if (!tx_req) begin
          state_nxt  = IDLE;
          frozen_nxt = 1'b1;
        end else if (!ch_idle) begin
          restart_ifs = 1'b1;
        end else if (!in_slots) begin
          if (clk_cnt == sifs_len - CNT_W'(1)) begin
            clk_cnt_nxt = '0;
            if (aifsn_r == 4'd0) begin
              ifs_done = 1'b1;
            end else begin
              in_slots_nxt = 1'b1;
            end
          end else begin
            clk_cnt_nxt = clk_cnt + CNT_W'(1);
          end
        end else begin
          if (clk_cnt == slot_len - CNT_W'(1)) begin
            clk_cnt_nxt = '0;
            if (aifs_cnt == aifsn_r - 4'd1) begin
              ifs_done = 1'b1;
            end else begin
              aifs_cnt_nxt = aifs_cnt + 4'd1;
            end
          end else begin
            clk_cnt_nxt = clk_cnt + CNT_W'(1);
          end
        end
        if (ifs_done) begin
          in_slots_nxt = 1'b0;
          aifs_cnt_nxt = 4'd0;
          state_nxt    = (bo_slots_left == '0) ? GRANT : BACKOFF;
        end
      end

      BACKOFF: begin
        if (!tx_req) begin
          state_nxt  = IDLE;
          frozen_nxt = 1'b1;
        end else if (!ch_idle) begin
          // Busy beats a coincident slot end: count frozen, partial slot dropped
          state_nxt   = IFS_WAIT;
          restart_ifs = 1'b1;
        end else if (clk_cnt == slot_len - CNT_W'(1)) begin
          clk_cnt_nxt = '0;
          left_nxt    = bo_slots_left - BO_W'(1);
          if (bo_slots_left == BO_W'(1)) begin
            state_nxt = GRANT;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      GRANT: begin
        state_nxt  = IDLE;
        frozen_nxt = 1'b0;
      end

      default: state_nxt = IDLE;
    endcase

    // Every IFS start (entry or busy restart) resamples the timing config
    if (restart_ifs) begin
      clk_cnt_nxt  = '0;
      in_slots_nxt = 1'b0;
      aifs_cnt_nxt = 4'd0;
      sifs_len_nxt = max1(sifs_clks);
      slot_len_nxt = max1(slot_clks);
      aifsn_nxt    = aifsn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      in_slots      <= 1'b0;
      aifs_cnt      <= 4'd0;
      sifs_len      <= '0;
      slot_len      <= '0;
      aifsn_r       <= 4'd0;
      bo_slots_left <= '0;
      frozen        <= 1'b0;
    end else begin
      state         <= state_nxt;
      clk_cnt       <= clk_cnt_nxt;
      in_slots      <= in_slots_nxt;
      aifs_cnt      <= aifs_cnt_nxt;
      sifs_len      <= sifs_len_nxt;
      slot_len      <= slot_len_nxt;
      aifsn_r       <= aifsn_nxt;
      bo_slots_left <= left_nxt;
      frozen        <= frozen_nxt;
    end
  end

  assign tx_grant = (state == GRANT);
  assign bo_busy  = (state == IFS_WAIT) || (state == BACKOFF);

`ifdef CSMA_FREEZE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      freeze_cnt <= 16'h0000;
    end else if (state == GRANT) begin
      freeze_cnt <= 16'h0000;
    end else if ((state == BACKOFF) && tx_req && !ch_idle && (freeze_cnt != 16'hFFFF)) begin
      freeze_cnt <= freeze_cnt + 16'h0001;
    end
  end
`endif

endmodule
